// File: rtl/spi_pkg.sv
// Shared SPI register definitions: bit positions and reset values used by the
// SPCR, SPCR2 and baud register blocks.
package spi_pkg;

    localparam int SPIE_BIT  = 7;
    localparam int SPE_BIT   = 6;
    localparam int SPTIE_BIT = 5;
    localparam int MSTR_BIT  = 4;
    localparam int CPOL_BIT  = 3;
    localparam int CPHA_BIT  = 2;
    localparam int SSOE_BIT  = 1;
    localparam int LSBFE_BIT = 0;

    localparam logic [7:0] SPCR_RESET = 8'h04;

endpackage

// File: rtl/spcr_reg.sv
// SPI control register 1: plain 8-bit storage captured every clock, with each
// control bit broken out for the SPI core, baud generator and shifter.
module spcr_reg
    import spi_pkg::*;
#(
    parameter logic [7:0] RESET_VAL = SPCR_RESET
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] SPCR_in,
    output logic       SPE,
    output logic       MSTR,
    output logic       CPOL,
    output logic       CPHA,
    output logic       LSBFE,
    output logic       SPIE,
    output logic       SPTIE,
    output logic       SSOE,
    output logic [7:0] SPCR_out
);

    logic [7:0] spcr_d;
    logic [7:0] spcr_q;

    // No write enable: the bus side presents the full next value every cycle.
    always_comb begin
        spcr_d = SPCR_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spcr_q <= RESET_VAL;
        end else begin
            spcr_q <= spcr_d;
        end
    end

    assign SPIE     = spcr_q[SPIE_BIT];
    assign SPE      = spcr_q[SPE_BIT];
    assign SPTIE    = spcr_q[SPTIE_BIT];
    assign MSTR     = spcr_q[MSTR_BIT];
    assign CPOL     = spcr_q[CPOL_BIT];
    assign CPHA     = spcr_q[CPHA_BIT];
    assign SSOE     = spcr_q[SSOE_BIT];
    assign LSBFE    = spcr_q[LSBFE_BIT];
    assign SPCR_out = spcr_q;

endmodule

// File: tb/tb_spcr_reg.sv
// Self-checking bench for spcr_reg: expected register values are queued as
// stimulus is driven and popped for comparison after the capturing edge.
module tb_spcr_reg;

    logic       clk;
    logic       rst;
    logic [7:0] SPCR_in;
    logic       SPE, MSTR, CPOL, CPHA, LSBFE, SPIE, SPTIE, SSOE;
    logic [7:0] SPCR_out;
    logic [7:0] bits_w;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];

    spcr_reg dut (
        .clk      (clk),
        .rst      (rst),
        .SPCR_in  (SPCR_in),
        .SPE      (SPE),
        .MSTR     (MSTR),
        .CPOL     (CPOL),
        .CPHA     (CPHA),
        .LSBFE    (LSBFE),
        .SPIE     (SPIE),
        .SPTIE    (SPTIE),
        .SSOE     (SSOE),
        .SPCR_out (SPCR_out)
    );

    // Individual outputs reassembled in the documented bit order.
    assign bits_w = {SPIE, SPE, SPTIE, MSTR, CPOL, CPHA, SSOE, LSBFE};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [7:0] exp);
        chk({tag, "_out"}, SPCR_out, exp);
        chk({tag, "_bits"}, bits_w, exp);
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got %02h expected a queued value", tag, SPCR_out);
        end else begin
            e = exp_q.pop_front();
            chk_state(tag, e);
        end
    endtask

    // Called just after a falling edge: drive, capture on the rising edge,
    // compare at the following falling edge.
    task automatic drive_edge(input string tag, input logic [7:0] v);
        SPCR_in = v;
        exp_q.push_back(v);
        @(posedge clk);
        @(negedge clk);
        pop_check(tag);
    endtask

    initial begin
        rst     = 1'b1;
        SPCR_in = 8'hFF;
        #1 rst  = 1'b0;

        // 1: reset held across several clock edges with all-ones input
        repeat (3) begin
            @(negedge clk);
            chk_state("rst_hold", 8'h04);
        end
        chk("rst_cpha", {7'b0, CPHA}, 8'h01);

        // 2: first capture after release
        #1 rst = 1'b1;
        drive_edge("cap_1c", 8'b0001_1100);
        chk("cap_1c_mstr", {7'b0, MSTR}, 8'h01);
        chk("cap_1c_cpol", {7'b0, CPOL}, 8'h01);

        // 3: asynchronous reset mid-cycle, input changes ignored
        #1 rst = 1'b0;
        #1 chk_state("async_rst", 8'h04);
        SPCR_in = 8'b0011_1010;
        @(negedge clk);
        chk_state("rst_ignore_in", 8'h04);

        // 4: release, value visible only after the next rising edge
        #1 rst = 1'b1;
        #1 chk_state("pre_edge", 8'h04);
        exp_q.push_back(8'h3A);
        @(posedge clk);
        @(negedge clk);
        pop_check("cap_3a");
        chk("cap_3a_cpha", {7'b0, CPHA}, 8'h00);
        chk("cap_3a_sptie", {7'b0, SPTIE}, 8'h01);

        // 5: walking one across all bits
        for (int k = 0; k < 8; k++) begin
            #1 drive_edge($sformatf("walk%0d", k), 8'h01 << k);
        end

        // 6: input changes between edges; only the value at the edge lands
        #1 SPCR_in = 8'hC1;
        #1 chk_state("between_c1", 8'h80);
        SPCR_in = 8'h00;
        #1 chk_state("between_00", 8'h80);
        drive_edge("edge_00", 8'h00);

        // A few random values back to back
        for (int i = 0; i < 6; i++) begin
            #1 drive_edge("rand", 8'($urandom_range(0, 255)));
        end

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_drain: %0d entries left expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
